// File: rtl/ventilador_pkg.sv
// ---------------------------------------------------------------------------
// ventilador_pkg
// Shared types for the fan controller: FSM state encoding (visible on the
// state output port), temperature zone encoding and their widths.
// ---------------------------------------------------------------------------
package ventilador_pkg;

  localparam int STATE_W = 2;
  localparam int ZONE_W  = 2;

  // Encoding is externally visible: OFF=0 KICK=1 RAMP=2 RUN=3.
  typedef enum logic [STATE_W-1:0] {
    ST_OFF  = 2'd0,
    ST_KICK = 2'd1,
    ST_RAMP = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  typedef enum logic [ZONE_W-1:0] {
    ZONE_LOW  = 2'd0,
    ZONE_MID  = 2'd1,
    ZONE_HIGH = 2'd2
  } zone_t;

endpackage

// File: rtl/ventilador_pwm_gen.sv
// ---------------------------------------------------------------------------
// ventilador_pwm_gen
// Glitch-free PWM generator. The counter runs 0 .. 2^PWM_BITS-2, so one
// period is 2^PWM_BITS-1 cycles and duty = 2^PWM_BITS-1 means always high.
// The commanded duty is captured only when the counter is at zero, so a duty
// change never truncates or stretches a pulse already in progress.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   enable   in   gate for the output (low forces pwm_out low next cycle)
//   duty     in   commanded duty, PWM_BITS wide
//   pwm_out  out  registered PWM drive
// ---------------------------------------------------------------------------
module ventilador_pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_out
);

  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((1 << PWM_BITS) - 2);

  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic [PWM_BITS-1:0] duty_lat_reg;
  logic                pwm_out_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_reg  <= '0;
      duty_lat_reg <= '0;
      pwm_out_reg  <= 1'b0;
    end else begin
      pwm_cnt_reg <= (pwm_cnt_reg == CNT_LAST) ? '0 : pwm_cnt_reg + PWM_BITS'(1);
      if (pwm_cnt_reg == '0) begin
        duty_lat_reg <= duty;
      end
      pwm_out_reg <= enable && (pwm_cnt_reg < duty_lat_reg);
    end
  end

  assign pwm_out = pwm_out_reg;

endmodule

// File: rtl/ventilador_pwm.sv
// ---------------------------------------------------------------------------
// ventilador_pwm
// Single-channel fan controller: kick-start at full duty after power-on,
// ramp of one LSB every RAMP_DIV cycles toward a zone target, three
// temperature zones with hysteresis, manual boost and a PWM output stage.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   power_on  in   fan enable (level); low forces OFF from any state
//   boost     in   manual override to DUTY_MAX (level)
//   temp      in   unsigned temperature, TEMP_W wide, sampled every cycle
//   fan_on    out  high in every state except OFF
//   pwm_out   out  PWM drive to the fan
//   duty      out  commanded duty (registered)
//   state     out  FSM state: OFF=0 KICK=1 RAMP=2 RUN=3
// ---------------------------------------------------------------------------
module ventilador_pwm
  import ventilador_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int TEMP_W   = 8,
  parameter int T_MID    = 40,
  parameter int T_HI     = 60,
  parameter int HYST     = 5,
  parameter int DUTY_MIN = 64,
  parameter int DUTY_MID = 160,
  parameter int DUTY_MAX = 255,
  parameter int KICK_CYC = 1024,
  parameter int RAMP_DIV = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                power_on,
  input  logic                boost,
  input  logic [TEMP_W-1:0]   temp,
  output logic                fan_on,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] duty,
  output logic [STATE_W-1:0]  state
);

  localparam int KICK_W = (KICK_CYC > 1) ? $clog2(KICK_CYC) : 1;
  localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [KICK_W-1:0]   KICK_LAST = KICK_W'(KICK_CYC - 1);
  localparam logic [RAMP_W-1:0]   RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
  localparam logic [PWM_BITS-1:0] D_MIN     = PWM_BITS'(DUTY_MIN);
  localparam logic [PWM_BITS-1:0] D_MID     = PWM_BITS'(DUTY_MID);
  localparam logic [PWM_BITS-1:0] D_MAX     = PWM_BITS'(DUTY_MAX);
  localparam logic [TEMP_W-1:0]   TH_HI     = TEMP_W'(T_HI);
  localparam logic [TEMP_W-1:0]   TH_HI_REL = TEMP_W'(T_HI - HYST);
  localparam logic [TEMP_W-1:0]   TH_MID    = TEMP_W'(T_MID);
  localparam logic [TEMP_W-1:0]   TH_MID_REL = TEMP_W'(T_MID - HYST);

  state_t              state_reg;
  zone_t               zone_reg;
  zone_t               zone_next;
  logic [PWM_BITS-1:0] duty_reg;
  logic [PWM_BITS-1:0] target;
  logic [PWM_BITS-1:0] duty_step;
  logic [KICK_W-1:0]   kick_cnt_reg;
  logic [RAMP_W-1:0]   ramp_cnt_reg;
  logic                fan_on_reg;

  // Zone with hysteresis: a zone is entered at its threshold and left only
  // once temp falls HYST below it.
  always_comb begin
    zone_next = ZONE_LOW;
    if (temp >= TH_HI) begin
      zone_next = ZONE_HIGH;
    end else if (zone_reg == ZONE_HIGH && temp >= TH_HI_REL) begin
      zone_next = ZONE_HIGH;
    end else if (temp >= TH_MID) begin
      zone_next = ZONE_MID;
    end else if (zone_reg != ZONE_LOW && temp >= TH_MID_REL) begin
      zone_next = ZONE_MID;
    end
  end

  always_comb begin
    target = D_MIN;
    if (boost) begin
      target = D_MAX;
    end else begin
      case (zone_reg)
        ZONE_HIGH: target = D_MAX;
        ZONE_MID:  target = D_MID;
        default:   target = D_MIN;
      endcase
    end
  end

  // Only consumed when duty_reg != target, so a single LSB step can neither
  // wrap nor overshoot the target.
  assign duty_step = (duty_reg < target) ? duty_reg + PWM_BITS'(1)
                                         : duty_reg - PWM_BITS'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_OFF;
      zone_reg     <= ZONE_LOW;
      duty_reg     <= '0;
      kick_cnt_reg <= '0;
      ramp_cnt_reg <= '0;
      fan_on_reg   <= 1'b0;
    end else begin
      zone_reg <= zone_next;
      if (!power_on) begin
        state_reg  <= ST_OFF;
        duty_reg   <= '0;
        fan_on_reg <= 1'b0;
      end else begin
        fan_on_reg <= 1'b1;
        case (state_reg)
          ST_OFF: begin
            state_reg    <= ST_KICK;
            duty_reg     <= D_MAX;
            kick_cnt_reg <= '0;
          end
          ST_KICK: begin
            duty_reg <= D_MAX;
            if (kick_cnt_reg == KICK_LAST) begin
              state_reg    <= ST_RAMP;
              ramp_cnt_reg <= '0;
            end else begin
              kick_cnt_reg <= kick_cnt_reg + KICK_W'(1);
            end
          end
          ST_RAMP: begin
            if (boost) begin
              duty_reg  <= D_MAX;
              state_reg <= ST_RUN;
            end else if (duty_reg == target) begin
              state_reg <= ST_RUN;
            end else if (ramp_cnt_reg == RAMP_LAST) begin
              ramp_cnt_reg <= '0;
              duty_reg     <= duty_step;
              // Leave on the step that lands on the target, not a cycle later.
              if (duty_step == target) begin
                state_reg <= ST_RUN;
              end
            end else begin
              ramp_cnt_reg <= ramp_cnt_reg + RAMP_W'(1);
            end
          end
          default: begin // ST_RUN
            if (boost) begin
              duty_reg <= D_MAX;
            end else if (duty_reg != target) begin
              state_reg    <= ST_RAMP;
              ramp_cnt_reg <= '0;
            end
          end
        endcase
      end
    end
  end

  // The FSM is non-OFF next cycle exactly when power_on is high, so power_on
  // is the enable that lines pwm_out up with the state it will be shown in.
  ventilador_pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (power_on),
    .duty    (duty_reg),
    .pwm_out (pwm_out)
  );

  assign fan_on = fan_on_reg;
  assign duty   = duty_reg;
  assign state  = state_reg;

endmodule
